// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: scan states, segment and anode constants shared by the bcd_display_scan slice
package bcd_disp_pkg;
    typedef enum logic [1:0] {S_ONES, S_TENS, S_HUND, S_OFF} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] AN_ONES   = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;
    localparam logic [3:0] AN_HUND   = 4'b1011;
    localparam logic [3:0] AN_OFF    = 4'b1111;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit d[3:0] to active-low seg[6:0] {g,f,e,d,c,b,a}, dash for codes 10-15
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] d,
    output logic [6:0] seg
);
    always_comb begin
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 4-digit common-anode scan of held BCD h/t/o (load strobe) to registered seg/an, dp off; LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] cnt;
    logic [3:0]    h_q, t_q, o_q, digit, an_nxt;
    logic [6:0]    glyph;
    logic          tick, blank;
    state_t        state;
    assign tick = cnt == CW'(REFRESH_DIV - 1);
    assign dp   = 1'b1;
    always_comb begin
        digit  = state == S_ONES ? o_q : state == S_TENS ? t_q : h_q;
        an_nxt = state == S_ONES ? AN_ONES : state == S_TENS ? AN_TENS :
                 state == S_HUND ? AN_HUND : AN_OFF;
`ifdef LEADING_ZERO_BLANK_EN
        blank  = state == S_OFF || (state == S_HUND && h_q == 4'd0) ||
                 (state == S_TENS && h_q == 4'd0 && t_q == 4'd0);
`else
        blank  = state == S_OFF;
`endif
    end
    bcd_to_7seg u_dec (.d(digit), .seg(glyph));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            t_q   <= '0;
            o_q   <= '0;
            cnt   <= '0;
            state <= S_ONES;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
        end else begin
            if (load) begin
                h_q <= hundreds;
                t_q <= tens;
                o_q <= ones;
            end
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) state <= state_t'(state + 2'd1);
            seg <= blank ? SEG_BLANK : glyph;
            an  <= an_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized scoreboard bench for bcd_display_scan against a slot-arithmetic display model
module tb_bcd_display_scan;
    localparam int R = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] hundreds = '0, tens = '0, ones = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    int         checks = 0;
    int         failures = 0;
    int         k = 0;
    logic [3:0] mh = '0, mt = '0, mo = '0;
    logic [10:0] exp_q[$];
    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    always #5 clk = ~clk;
    bcd_display_scan #(.REFRESH_DIV(R)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .hundreds(hundreds), .tens(tens), .ones(ones),
        .seg(seg), .an(an), .dp(dp)
    );
    function automatic logic [6:0] glyph(input logic [3:0] v);
        return v > 4'd9 ? 7'b0111111 : glyph_tab[v];
    endfunction
    function automatic logic [10:0] expect_pins(input int kk);
        int   slot;
        logic hb, tb;
        slot = ((kk - 1) / R) % 4;
`ifdef LEADING_ZERO_BLANK_EN
        hb = mh == 4'd0;
        tb = mh == 4'd0 && mt == 4'd0;
`else
        hb = 1'b0;
        tb = 1'b0;
`endif
        case (slot)
            0:       return {glyph(mo), 4'b1110};
            1:       return {tb ? 7'h7f : glyph(mt), 4'b1101};
            2:       return {hb ? 7'h7f : glyph(mh), 4'b1011};
            default: return {7'h7f, 4'b1111};
        endcase
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            check("pins", {21'd0, seg, an}, {21'd0, e});
            check("dp", {31'd0, dp}, 32'd1);
        end
    end
    task automatic step(input bit ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        k++;
        exp_q.push_back(expect_pins(k));
        load = ld;
        hundreds = h;
        tens = t;
        ones = o;
        if (ld) {mh, mt, mo} = {h, t, o};
        @(negedge clk);
    endtask
    task automatic idle_steps(input int n, input int load_one_in);
        for (int i = 0; i < n; i++)
            step(load_one_in > 0 && $urandom_range(load_one_in - 1) == 0,
                 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_seg", {25'd0, seg}, 32'h7f);
        check("reset_an", {28'd0, an}, 32'hf);
        check("reset_dp", {31'd0, dp}, 32'd1);
        rst_n = 1'b1;
        k = 0;
        {mh, mt, mo} = '0;
    endtask
    initial begin
        do_reset();
        step(1, 4'd1, 4'd8, 4'd6);
        idle_steps(4 * R + 2, 0);
        step(1, 4'd2, 4'd2, 4'd2);
        idle_steps(4, 0);
        step(1, 4'hc, 4'd3, 4'd4);
        idle_steps(4 * R, 0);
        step(1, 4'd0, 4'd1, 4'd2);
        idle_steps(4 * R, 0);
        step(1, 4'd0, 4'd0, 4'd0);
        idle_steps(4 * R, 0);
        do_reset();
        step(1, 4'd5, 4'd5, 4'd5);
        idle_steps(R + 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg", {25'd0, seg}, 32'h7f);
        check("async_an", {28'd0, an}, 32'hf);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        {mh, mt, mo} = '0;
        idle_steps(4 * R, 0);
        idle_steps(300, 6);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
